wb_periph_sequencer: RTL and testbench



---
 rtl/wb_periph_sequencer_pkg.sv | 18 +
 rtl/wb_periph_sequencer_if.sv | 44 ++++
 rtl/wb_periph_sequencer.sv | 151 +++++++++++++++
 tb/tb_wb_periph_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_periph_sequencer_pkg.sv
// Shared types and constants for the Wishbone peripheral sequencer:
// FSM state encoding, peripheral slot numbers and the error read word.
package wb_periph_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] SLOT_SPI0 = 2'd0;
    localparam logic [1:0] SLOT_SPI1 = 2'd1;
    localparam logic [1:0] SLOT_I2C  = 2'd2;
    localparam logic [1:0] SLOT_GPIO = 2'd3;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/wb_periph_sequencer_if.sv
// Host-side Wishbone slave port, peripheral-side bus and FSM debug view of
// the sequencer, bundled so the DUT and the bench share one definition.
interface wb_periph_sequencer_if;
    import wb_periph_pkg::*;

    // Handshake: the host holds wbs_cyc_i/wbs_stb_i and its request until it
    // sees the one-cycle wbs_ack_o; the sequencer holds p_cyc_o/p_stb_o and the
    // latched request until the selected slot returns p_ack_i.
    logic         wbs_cyc_i;
    logic         wbs_stb_i;
    logic         wbs_we_i;
    logic [3:0]   wbs_sel_i;
    logic [31:0]  wbs_adr_i;
    logic [31:0]  wbs_dat_i;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic         p_cyc_o;
    logic [3:0]   p_stb_o;
    logic         p_we_o;
    logic [3:0]   p_sel_o;
    logic [31:0]  p_adr_o;
    logic [31:0]  p_dat_o;
    logic [3:0]   p_ack_i;
    logic [127:0] p_dat_i;
    logic         bus_err_o;
    state_t       fsm_state;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  p_ack_i, p_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output p_cyc_o, p_stb_o, p_we_o, p_sel_o, p_adr_o, p_dat_o,
        output bus_err_o, fsm_state
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output p_ack_i, p_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  p_cyc_o, p_stb_o, p_we_o, p_sel_o, p_adr_o, p_dat_o,
        input  bus_err_o, fsm_state
    );

endinterface

// File: rtl/wb_periph_sequencer.sv
// Registered Wishbone front-end routing one host access at a time to SPI0/SPI1/I2C/GPIO8.
// Define WB_PERIPH_SEQ_TIMEOUT_EN to add the bus-timeout watchdog and sticky bus_err_o.
module wb_periph_sequencer
    import wb_periph_pkg::*;
#(
    parameter int          NUM_SLOTS      = 4,
    parameter int          SLOT_LSB       = 16,
`ifdef WB_PERIPH_SEQ_TIMEOUT_EN
    parameter int          TIMEOUT_CYCLES = 255,
`endif
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_periph_sequencer_if.slave  bus
);

    function automatic logic [31:0] slot_word(input logic [NUM_SLOTS*32-1:0] words,
                                              input logic [1:0] slot);
        return words[32*slot +: 32];
    endfunction

    state_t                state, state_next;
    logic                  cyc_q, cyc_next;
    logic [NUM_SLOTS-1:0]  stb_q, stb_next;
    logic                  we_q, we_next;
    logic [3:0]            sel_q, sel_next;
    logic [31:0]           adr_q, adr_next;
    logic [31:0]           dat_q, dat_next;
    logic [31:0]           rdata_q, rdata_next;
    logic                  ack_q, ack_next;
    logic                  err_q, err_next;
    logic                  req;
    logic                  sel_ack;
    logic                  timeout_hit;

    assign req     = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack_q;
    // stb_q is one-hot, so masking the acks keeps only the selected slot's.
    assign sel_ack = |(bus.p_ack_i & stb_q);

`ifdef WB_PERIPH_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt <= '0;
        end else if (state != ACTIVE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th ACTIVE cycle; a real ack that cycle wins.
    assign timeout_hit = (state == ACTIVE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cyc_next   = cyc_q;
        stb_next   = stb_q;
        we_next    = we_q;
        sel_next   = sel_q;
        adr_next   = adr_q;
        dat_next   = dat_q;
        rdata_next = rdata_q;
        ack_next   = 1'b0;
        err_next   = err_q;
        case (state)
            IDLE: begin
                if (req) begin
                    we_next    = bus.wbs_we_i;
                    sel_next   = bus.wbs_sel_i;
                    adr_next   = bus.wbs_adr_i;
                    dat_next   = bus.wbs_dat_i;
                    cyc_next   = 1'b1;
                    stb_next   = NUM_SLOTS'(1) << bus.wbs_adr_i[SLOT_LSB +: 2];
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!bus.wbs_cyc_i) begin
                    cyc_next   = 1'b0;
                    stb_next   = '0;
                    state_next = IDLE;
                end else if (sel_ack) begin
                    rdata_next = slot_word(bus.p_dat_i, adr_q[SLOT_LSB +: 2]);
                    cyc_next   = 1'b0;
                    stb_next   = '0;
                    ack_next   = 1'b1;
                    state_next = RESP;
                end else if (timeout_hit) begin
                    rdata_next = ERR_DATA;
                    err_next   = 1'b1;
                    cyc_next   = 1'b0;
                    stb_next   = '0;
                    ack_next   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            cyc_q   <= cyc_next;
            stb_q   <= stb_next;
            we_q    <= we_next;
            sel_q   <= sel_next;
            adr_q   <= adr_next;
            dat_q   <= dat_next;
            rdata_q <= rdata_next;
            ack_q   <= ack_next;
            err_q   <= err_next;
        end
    end

    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = rdata_q;
    assign bus.p_cyc_o   = cyc_q;
    assign bus.p_stb_o   = stb_q;
    assign bus.p_we_o    = we_q;
    assign bus.p_sel_o   = sel_q;
    assign bus.p_adr_o   = adr_q;
    assign bus.p_dat_o   = dat_q;
    assign bus.bus_err_o = err_q;
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_wb_periph_sequencer.sv
// Directed bench for wb_periph_sequencer: host accesses push expected peripheral
// requests and host responses into queues that negedge monitors pop and compare.
module tb_wb_periph_sequencer;
    import wb_periph_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_periph_sequencer_if bus ();

    wb_periph_sequencer #(
`ifdef WB_PERIPH_SEQ_TIMEOUT_EN
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_n  = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Peripheral model: slot s acks lat[s] cycles after its strobe appears (-1 = never)
    logic [31:0] slot_data [4];
    int          lat [4];
    logic        spur0 = 1'b0;
    logic [3:0]  model_ack = '0;
    logic [3:0]  force_ack = '0;
    int          age = 0;

    assign bus.p_ack_i = model_ack | force_ack;
    assign bus.p_dat_i = {slot_data[3], slot_data[2], slot_data[1], slot_data[0]};

    always @(negedge clk) begin
        model_ack = '0;
        if (bus.p_cyc_o) begin
            age++;
            for (int s = 0; s < 4; s++)
                if (bus.p_stb_o[s] && lat[s] >= 0 && age == lat[s] + 1) model_ack[s] = 1'b1;
            if (spur0 && bus.p_stb_o[1]) model_ack[0] = 1'b1;
        end else begin
            age = 0;
        end
    end

    // Scoreboard queues
    logic [72:0] exp_req_q[$];
    int          exp_req_cyc_q[$];
    logic [31:0] exp_dat_q[$];
    int          exp_ack_cyc_q[$];

    logic        prev_cyc = 1'b0;
    logic [72:0] held_req = '0;
    logic [72:0] cur_req;

    always @(negedge clk) begin
        cur_req = {bus.p_stb_o, bus.p_we_o, bus.p_sel_o, bus.p_adr_o, bus.p_dat_o};
        if (!rst) begin
            if (bus.p_cyc_o && !prev_cyc) begin
                if (exp_req_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_req: got %0h, expected none (cycle %0d)", cur_req, cyc_n);
                end else begin
                    check("req_fields", cur_req, exp_req_q.pop_front());
                    check("req_cycle", cyc_n, exp_req_cyc_q.pop_front());
                end
                held_req = cur_req;
            end else if (bus.p_cyc_o) begin
                check("req_stable", cur_req, held_req);
            end
            if (bus.wbs_ack_o) begin
                if (exp_dat_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got ack with data %0h, expected no ack (cycle %0d)",
                             bus.wbs_dat_o, cyc_n);
                end else begin
                    check("ack_data", bus.wbs_dat_o, exp_dat_q.pop_front());
                    check("ack_cycle", cyc_n, exp_ack_cyc_q.pop_front());
                end
            end
        end
        prev_cyc = bus.p_cyc_o;
    end

    task automatic host_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = '0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
    endtask

    task automatic host_req(input logic [31:0] adr, input logic [31:0] dat,
                            input logic we, input logic [3:0] sel);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
    endtask

    // Full access; ack_ofs is the hand-computed host ack cycle relative to the request cycle
    task automatic do_access(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                             input logic [3:0] sel, input logic [3:0] exp_stb,
                             input logic [31:0] exp_rd, input int ack_ofs);
        int c0;
        bit got;
        @(negedge clk);
        host_req(adr, dat, we, sel);
        c0 = cyc_n;
        exp_req_q.push_back({exp_stb, we, sel, adr, dat});
        exp_req_cyc_q.push_back(c0 + 1);
        exp_dat_q.push_back(exp_rd);
        exp_ack_cyc_q.push_back(c0 + ack_ofs);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) got = 1'b1;
        end
        host_idle();
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL access_timeout: got no ack in 50 cycles, expected ack for adr %0h", adr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        slot_data[0] = 32'h0F0F_1234;
        slot_data[1] = 32'h5A5A_0101;
        slot_data[2] = 32'h1234_5678;
        slot_data[3] = 32'h0000_00C3;
        for (int s = 0; s < 4; s++) lat[s] = -1;
        host_idle();

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_state", bus.fsm_state, IDLE);
        check("rst_outputs", {bus.wbs_ack_o, bus.p_cyc_o, bus.p_stb_o, bus.p_we_o, bus.p_sel_o, bus.bus_err_o}, '0);
        check("rst_data", {bus.p_adr_o, bus.p_dat_o, bus.wbs_dat_o}, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // SPI0 write, peripheral acks two cycles after its strobe
        lat[0] = 2;
        do_access(32'h0000_0010, 32'hA5A5_0001, 1'b1, 4'hF, 4'b0001, 32'h0F0F_1234, 4);

        // GPIO read, peripheral answers the cycle after its strobe
        lat[3] = 1;
        do_access(32'h0003_0004, 32'h0, 1'b0, 4'hF, 4'b1000, 32'h0000_00C3, 3);

        // I2C access aborted by the host; late I2C ack must be dropped
        @(negedge clk);
        host_req(32'h0002_0008, 32'h0, 1'b0, 4'hF);
        c0 = cyc_n;
        exp_req_q.push_back({4'b0100, 1'b0, 4'hF, 32'h0002_0008, 32'h0});
        exp_req_cyc_q.push_back(c0 + 1);
        @(negedge clk);
        @(negedge clk);
        host_idle();
        @(negedge clk);
        force_ack[2] = 1'b1;
        check("abort_cyc", bus.p_cyc_o, 1'b0);
        check("abort_stb", bus.p_stb_o, 4'b0000);
        check("abort_state", bus.fsm_state, IDLE);
        @(negedge clk);
        force_ack[2] = 1'b0;
        check("abort_state_after_ack", bus.fsm_state, IDLE);
        check("abort_dat_held", bus.wbs_dat_o, 32'h0000_00C3);
        @(negedge clk);

        // SPI1 read with spurious slot-0 acks during the access
        lat[1] = 3;
        spur0  = 1'b1;
        do_access(32'h0001_000C, 32'h0, 1'b0, 4'b0110, 4'b0010, 32'h5A5A_0101, 5);
        spur0  = 1'b0;

`ifdef WB_PERIPH_SEQ_TIMEOUT_EN
        // SPI0 never acks: error ack after 8 ACTIVE cycles, sticky bus_err_o
        lat[0] = -1;
        do_access(32'h0000_0020, 32'h0, 1'b0, 4'hF, 4'b0001, 32'hDEAD_BEEF, 9);
        check("timeout_err_set", bus.bus_err_o, 1'b1);
        do_access(32'h0003_0000, 32'h0, 1'b0, 4'hF, 4'b1000, 32'h0000_00C3, 3);
        check("timeout_err_sticky", bus.bus_err_o, 1'b1);
`else
        check("no_bus_err", bus.bus_err_o, 1'b0);
`endif

        // Asynchronous reset while ACTIVE
        lat[0] = -1;
        @(negedge clk);
        host_req(32'h0000_0040, 32'h1357_9BDF, 1'b1, 4'b0011);
        c0 = cyc_n;
        exp_req_q.push_back({4'b0001, 1'b1, 4'b0011, 32'h0000_0040, 32'h1357_9BDF});
        exp_req_cyc_q.push_back(c0 + 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", bus.fsm_state, IDLE);
        check("async_rst_outputs", {bus.wbs_ack_o, bus.p_cyc_o, bus.p_stb_o, bus.p_we_o, bus.p_sel_o, bus.bus_err_o}, '0);
        check("async_rst_data", {bus.p_adr_o, bus.p_dat_o, bus.wbs_dat_o}, '0);
        host_idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Recovery access after reset
        lat[1] = 1;
        do_access(32'h0001_0100, 32'h0, 1'b0, 4'hF, 4'b0010, 32'h5A5A_0101, 3);

        repeat (4) @(negedge clk);
        check("drain_req_q", exp_req_q.size(), 0);
        check("drain_ack_q", exp_dat_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
